// File: rtl/sdram_refresh_gen.sv
// SDRAM auto-refresh generator: accrues refresh debt from an interval timer and,
// once granted, plays out PRECHARGE-all followed by a short burst of REFRESH commands.
module sdram_refresh_gen #(
  parameter int REF_INTERVAL = 750,
  parameter int TRP_CLK      = 2,
  parameter int TRFC_CLK     = 7,
  parameter int REF_BURST    = 2,
  parameter int MAX_DEBT     = 8,
  parameter int ADDR_W       = 13,
  parameter int BA_W         = 2
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           init_end,
  input  logic                           aref_en,
  output logic                           aref_req,
  output logic                           aref_urgent,
  output logic [3:0]                     aref_cmd,
  output logic [BA_W-1:0]                aref_ba,
  output logic [ADDR_W-1:0]              aref_addr,
  output logic                           aref_end,
  output logic [$clog2(MAX_DEBT+1)-1:0]  aref_debt,
  output logic                           aref_ovf
);

  localparam int DEBT_W  = $clog2(MAX_DEBT + 1);
  localparam int CNT_W   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int WAIT_MX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int WAIT_W  = $clog2(WAIT_MX + 1);
  localparam int BURST_W = $clog2(REF_BURST + 1);

  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE, S_PCHA, S_TRP, S_REF, S_TRFC, S_END
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_intervalCnt;
  logic [DEBT_W-1:0]   r_debt;
  logic                r_ovf;
  logic [WAIT_W-1:0]   r_wait;
  logic [BURST_W-1:0]  r_left;
  logic [3:0]          r_cmd;
  logic [BA_W-1:0]     r_ba;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          w_cmdNext;
  logic                w_tick;
  logic                w_grant;
  logic                w_issueRef;

  assign w_tick     = init_end && (r_intervalCnt == CNT_W'(REF_INTERVAL - 1));
  assign w_grant    = aref_en && aref_req;
  assign w_issueRef = (r_state == S_REF);

  assign aref_req    = (r_debt != '0) && (r_state == S_IDLE) && init_end;
  assign aref_urgent = (int'(r_debt) >= MAX_DEBT - 1);
  assign aref_end    = (r_state == S_END);
  assign aref_cmd    = r_cmd;
  assign aref_ba     = r_ba;
  assign aref_addr   = r_addr;
  assign aref_debt   = r_debt;
  assign aref_ovf    = r_ovf;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Losing init_end aborts whatever is in flight; the command follows the next state.
  always_comb begin
    w_next    = r_state;
    w_cmdNext = CMD_NOP;
    if (!init_end) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) w_next = S_PCHA;
        S_PCHA: w_next = S_TRP;
        S_TRP:  if (r_wait == WAIT_W'(TRP_CLK - 1)) w_next = S_REF;
        S_REF:  w_next = S_TRFC;
        S_TRFC: if (r_wait == WAIT_W'(TRFC_CLK - 1))
                  w_next = (r_left != '0) ? S_REF : S_END;
        S_END:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
    if (w_next == S_PCHA)     w_cmdNext = CMD_PRE;
    else if (w_next == S_REF) w_cmdNext = CMD_REF;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cmd  <= CMD_NOP;
      r_ba   <= '1;
      r_addr <= '1;
    end else begin
      r_cmd  <= w_cmdNext;
      r_ba   <= '1;
      r_addr <= '1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wait <= '0;
      r_left <= '0;
    end else begin
      if ((w_next == r_state) && ((r_state == S_TRP) || (r_state == S_TRFC)))
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;
      // The burst length is frozen at grant so later ticks cannot extend it.
      if (r_state == S_IDLE && w_next == S_PCHA)
        r_left <= (int'(r_debt) > REF_BURST) ? BURST_W'(REF_BURST) : BURST_W'(r_debt);
      else if (w_issueRef && r_left != '0)
        r_left <= r_left - BURST_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_intervalCnt <= '0;
      r_debt        <= '0;
      r_ovf         <= 1'b0;
    end else if (!init_end) begin
      r_intervalCnt <= '0;
      r_debt        <= '0;
    end else begin
      r_intervalCnt <= w_tick ? '0 : r_intervalCnt + CNT_W'(1);
      if (w_tick && int'(r_debt) == MAX_DEBT)
        r_ovf <= 1'b1;
      if (w_tick && !w_issueRef) begin
        if (int'(r_debt) != MAX_DEBT) r_debt <= r_debt + DEBT_W'(1);
      end else if (!w_tick && w_issueRef && r_debt != '0) begin
        r_debt <= r_debt - DEBT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_refresh_gen.sv
// Randomised bench for sdram_refresh_gen: a command-queue reference model predicts
// every output each cycle; directed phases steer it into debt/burst/abort corners.
module tb_sdram_refresh_gen;

  localparam int REF_INTERVAL = 750;
  localparam int TRP_CLK      = 2;
  localparam int TRFC_CLK     = 7;
  localparam int REF_BURST    = 2;
  localparam int MAX_DEBT     = 8;
  localparam int ADDR_W       = 13;
  localparam int BA_W         = 2;
  localparam int DEBT_W       = $clog2(MAX_DEBT + 1);
  localparam int END_SLOT     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              initEnd;
  logic              arefEn;
  logic              arefReq;
  logic              arefUrgent;
  logic [3:0]        arefCmd;
  logic [BA_W-1:0]   arefBa;
  logic [ADDR_W-1:0] arefAddr;
  logic              arefEnd;
  logic [DEBT_W-1:0] arefDebt;
  logic              arefOvf;

  int testsRun    = 0;
  int testsFailed = 0;
  int refSeen     = 0;
  int endSeen     = 0;

  int mCnt;
  int mDebt;
  bit mOvf;
  int mQ[$];

  sdram_refresh_gen #(
    .REF_INTERVAL(REF_INTERVAL), .TRP_CLK(TRP_CLK), .TRFC_CLK(TRFC_CLK),
    .REF_BURST(REF_BURST), .MAX_DEBT(MAX_DEBT), .ADDR_W(ADDR_W), .BA_W(BA_W)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .init_end(initEnd), .aref_en(arefEn),
    .aref_req(arefReq), .aref_urgent(arefUrgent), .aref_cmd(arefCmd),
    .aref_ba(arefBa), .aref_addr(arefAddr), .aref_end(arefEnd),
    .aref_debt(arefDebt), .aref_ovf(arefOvf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCnt  = 0;
    mDebt = 0;
    mOvf  = 1'b0;
    mQ.delete();
  endtask

  // Each grant expands into the exact command list the bus must show, one entry per cycle.
  task automatic modelEdge(input bit en, input bit init);
    bit refNow;
    bit tick;
    bit idle;
    int owed;
    int n;
    refNow = (mQ.size() != 0) && (mQ[0] == 1);
    tick   = init && (mCnt == REF_INTERVAL - 1);
    idle   = (mQ.size() == 0);
    owed   = mDebt;
    if (!init) begin
      mCnt  = 0;
      mDebt = 0;
      mQ.delete();
    end else begin
      mCnt = (mCnt + 1) % REF_INTERVAL;
      if (tick && owed == MAX_DEBT) mOvf = 1'b1;
      mDebt = owed + int'(tick) - int'(refNow);
      if (mDebt > MAX_DEBT) mDebt = MAX_DEBT;
      if (!idle) begin
        void'(mQ.pop_front());
      end else if (en && owed != 0) begin
        n = (owed < REF_BURST) ? owed : REF_BURST;
        mQ.push_back(2);
        repeat (TRP_CLK) mQ.push_back(7);
        repeat (n) begin
          mQ.push_back(1);
          repeat (TRFC_CLK) mQ.push_back(7);
        end
        mQ.push_back(END_SLOT);
      end
    end
  endtask

  task automatic checkAll();
    int expCmd;
    bit expEnd;
    expCmd = (mQ.size() == 0 || mQ[0] == END_SLOT) ? 7 : mQ[0];
    expEnd = (mQ.size() != 0) && (mQ[0] == END_SLOT);
    checkOutput("cmd", 32'(arefCmd), expCmd);
    checkOutput("end", 32'(arefEnd), 32'(expEnd));
    checkOutput("req", 32'(arefReq), 32'((mDebt != 0) && (mQ.size() == 0) && initEnd && !rst));
    checkOutput("debt", 32'(arefDebt), mDebt);
    checkOutput("ovf", 32'(arefOvf), 32'(mOvf));
    checkOutput("urgent", 32'(arefUrgent), 32'(mDebt >= MAX_DEBT - 1));
    checkOutput("ba", 32'(arefBa), (1 << BA_W) - 1);
    checkOutput("addr", 32'(arefAddr), (1 << ADDR_W) - 1);
  endtask

  task automatic applyStimulus(input bit en, input bit init);
    arefEn  = en;
    initEnd = init;
    @(posedge clk);
    if (!rst) modelEdge(en, init);
    @(negedge clk);
    checkAll();
    if (arefCmd == 4'b0001) refSeen++;
    if (arefEnd) endSeen++;
  endtask

  task automatic waitDebt(input int target, input string tag);
    int guard;
    guard = 0;
    while (mDebt < target && guard < 12 * REF_INTERVAL) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    if (mDebt < target) checkOutput(tag, 32'(arefDebt), target);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int refBase;
    int endBase;
    int debtBefore;
    int guard;
    bit urgentChecked;
    rst     = 1'b1;
    initEnd = 1'b0;
    arefEn  = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;

    // First tick lands after exactly REF_INTERVAL clocks of init_end.
    repeat (REF_INTERVAL) applyStimulus(1'b0, 1'b1);
    checkOutput("first_tick_debt", 32'(arefDebt), 1);
    checkOutput("first_tick_req", 32'(arefReq), 1);

    waitDebt(2, "debt2_timeout");
    refBase = refSeen;
    endBase = endSeen;
    applyStimulus(1'b1, 1'b1);
    repeat (TRP_CLK + 2 * (1 + TRFC_CLK) + 3) applyStimulus(1'b0, 1'b1);
    checkOutput("burst2_refs", refSeen - refBase, 2);
    checkOutput("burst2_ends", endSeen - endBase, 1);
    checkOutput("burst2_debt", 32'(arefDebt), 0);
    checkOutput("burst2_req", 32'(arefReq), 0);

    waitDebt(3, "debt3_timeout");
    refBase = refSeen;
    applyStimulus(1'b1, 1'b1);
    repeat (TRP_CLK + 2 * (1 + TRFC_CLK) + 3) applyStimulus(1'b0, 1'b1);
    checkOutput("burst3_refs", refSeen - refBase, 2);
    checkOutput("burst3_debt", 32'(arefDebt), 1);
    checkOutput("burst3_req", 32'(arefReq), 1);

    urgentChecked = 1'b0;
    guard = 0;
    while (!mOvf && guard < 12 * REF_INTERVAL) begin
      applyStimulus(1'b0, 1'b1);
      if (mDebt == MAX_DEBT - 1 && !urgentChecked) begin
        checkOutput("urgent_at_7", 32'(arefUrgent), 1);
        urgentChecked = 1'b1;
      end
      guard++;
    end
    checkOutput("ovf_set", 32'(arefOvf), 1);
    checkOutput("ovf_debt", 32'(arefDebt), MAX_DEBT);

    // Line the grant up so the first REFRESH shares its cycle with a tick.
    guard = 0;
    while (!(mCnt == REF_INTERVAL - 1 - TRP_CLK - 2 && mQ.size() == 0 && mDebt > 0) && guard < 2 * REF_INTERVAL) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    applyStimulus(1'b1, 1'b1);
    repeat (TRP_CLK + 1) applyStimulus(1'b0, 1'b1);
    checkOutput("coinc_is_ref", 32'(arefCmd), 1);
    debtBefore = int'(arefDebt);
    applyStimulus(1'b0, 1'b1);
    checkOutput("coinc_debt", 32'(arefDebt), debtBefore);
    repeat (20) applyStimulus(1'b0, 1'b1);

    // Drop init_end while waiting out tRP.
    waitDebt(1, "abort_debt_timeout");
    endBase = endSeen;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("initdrop_cmd", 32'(arefCmd), 7);
    checkOutput("initdrop_debt", 32'(arefDebt), 0);
    repeat (20) applyStimulus(1'b1, 1'b0);
    checkOutput("initdrop_noend", endSeen - endBase, 0);

    // Asynchronous reset in the middle of tRFC.
    waitDebt(1, "rst_debt_timeout");
    endBase = endSeen;
    applyStimulus(1'b1, 1'b1);
    repeat (TRP_CLK + 3) applyStimulus(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    checkAll();
    rst = 1'b0;
    repeat (20) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_noend", endSeen - endBase, 0);

    for (int i = 0; i < 20000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1999) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sdram_refresh_gen.md
SDRAM_REFRESH_GEN -- requirements
Module: sdram_refresh_gen

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 750, meaning clocks per refresh tick (7.5 us at 100 MHz).
REQ-002 SHALL have parameter TRP_CLK, default 2, meaning NOP cycles between PRECHARGE and the first REFRESH.
REQ-003 SHALL have parameter TRFC_CLK, default 7, meaning NOP cycles after each REFRESH.
REQ-004 SHALL have parameter REF_BURST, default 2, meaning the maximum number of REFRESH commands per grant.
REQ-005 SHALL have parameter MAX_DEBT, default 8, meaning the maximum number of postponed refreshes.
REQ-006 SHALL have parameter ADDR_W, default 13, meaning address width.
REQ-007 SHALL have parameter BA_W, default 2, meaning bank-address width.
REQ-008 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-009 SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port init_end, input, 1 bit: SDRAM initialisation complete.
REQ-011 SHALL have port aref_en, input, 1 bit: arbiter grant.
REQ-012 SHALL have port aref_req, output, 1 bit: refresh request to the arbiter.
REQ-013 SHALL have port aref_urgent, output, 1 bit: debt is at least MAX_DEBT-1.
REQ-014 SHALL have port aref_cmd, output, 4 bits: {cs_n, ras_n, cas_n, we_n}.
REQ-015 SHALL have ports aref_ba (output, BA_W bits) and aref_addr (output, ADDR_W bits).
REQ-016 SHALL have port aref_end, output, 1 bit: one-cycle pulse marking burst done.
REQ-017 SHALL have ports aref_debt (output, clog2(MAX_DEBT+1) bits: owed refreshes) and aref_ovf (output, 1 bit: sticky debt overflow).

Function
REQ-018 Interval counter SHALL count while init_end=1, wrap from REF_INTERVAL-1 to 0, and emit a one-cycle tick at the wrap.
REQ-019 Each tick SHALL increment aref_debt, saturating at MAX_DEBT; a tick arriving at MAX_DEBT SHALL set aref_ovf, which is cleared only by reset.
REQ-020 Each REFRESH command issued SHALL decrement aref_debt by 1; a tick and a REFRESH in the same cycle SHALL leave aref_debt unchanged.
REQ-021 aref_req SHALL equal (aref_debt!=0) AND (state=IDLE) AND init_end; grant with aref_debt=0 or init_end=0 is ignored.
REQ-022 FSM states: IDLE, PCHA, TRP, REF, TRFC, END.
REQ-023 Transitions:
- IDLE->PCHA on aref_en & aref_req.
- PCHA->TRP after 1 cycle.
- TRP->REF after TRP_CLK cycles.
- REF->TRFC after 1 cycle.
- TRFC->REF after TRFC_CLK cycles if another refresh is due in the burst, else ->END.
- END->IDLE after 1 cycle.
REQ-024 Burst count N SHALL be latched at grant as min(aref_debt, REF_BURST); exactly N REFRESH commands SHALL be issued per grant.
REQ-025 Command encodings: PRECHARGE=4'b0010, REFRESH=4'b0001, NOP=4'b0111.
REQ-026 Command-bus sequence per grant: PRECHARGE for 1 cycle, TRP_CLK NOPs, then N times (REFRESH for 1 cycle, TRFC_CLK NOPs).
REQ-027 aref_ba SHALL be all ones and aref_addr all ones (A10=1, precharge-all) in every cycle.
REQ-028 aref_cmd/ba/addr SHALL be registered; every cycle outside PRECHARGE/REFRESH SHALL carry NOP.
REQ-029 aref_end SHALL pulse high for exactly 1 cycle, immediately after the last TRFC NOP cycle of the burst.
REQ-030 aref_urgent SHALL be combinational from aref_debt.
REQ-031 init_end falling in any state SHALL force IDLE on the next edge, clear the interval counter and aref_debt, drive NOP, and SHALL NOT pulse aref_end.
REQ-032 A grant held high through END SHALL start a new burst only if aref_req is high in IDLE.

Reset
REQ-033 sys_rst=1 SHALL asynchronously set the following, held until the first edge after release:
- state=IDLE, counters=0, aref_debt=0, aref_ovf=0.
- aref_req=0, aref_urgent=0, aref_end=0.
- aref_cmd=NOP, aref_ba/aref_addr=all ones.

Verification
REQ-034 Defaults; init_end rises at cycle 0 -> tick and aref_req=1 after 750 cycles, aref_debt=1.
REQ-035 Debt=2, grant -> bus shows PRE, 2 NOP, REF, 7 NOP, REF, 7 NOP; aref_end pulse the next cycle; debt=0; aref_req=0.
REQ-036 Grant withheld for 9 ticks -> aref_debt=7 with aref_urgent=1, then 8; aref_ovf=1 at the 9th tick.
REQ-037 Debt=3, REF_BURST=2, grant -> 2 REFRESH commands, aref_debt=1, aref_req re-asserts in IDLE.
REQ-038 Tick coinciding with a REFRESH cycle -> aref_debt unchanged that cycle.
REQ-039 sys_rst pulsed during TRFC, and separately init_end dropped during TRP -> immediate NOP, IDLE, debt=0, no aref_end pulse.
